// File: rtl/vl_pkg.sv
// -----------------------------------------------------------------------------
// vl_pkg
// Shared definitions for the vector loader:
//   - default sample width and vector length
//   - loader FSM state encoding
//   - tree_latency(n): pipeline depth of the downstream adder tree that
//     consumes a vector of n samples (two tree levels per register stage,
//     plus one output register).
// No ports (package).
// -----------------------------------------------------------------------------
package vl_pkg;

  localparam int DEFAULT_WIDTH      = 17;
  localparam int DEFAULT_INPUT_SIZE = 32;

  typedef enum logic {
    FILL  = 1'b0,
    ISSUE = 1'b1
  } vl_state_t;

  function automatic int tree_latency(input int n);
    return (($clog2(n) + 1) / 2) + 1;
  endfunction

endpackage

// File: rtl/vl_valid_delay.sv
// -----------------------------------------------------------------------------
// vl_valid_delay
// DEPTH-stage shift register that delays a single-bit valid flag so it lines
// up with the output of the downstream adder tree.
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset, clears every stage
//   in_valid   in   flag to be delayed
//   out_valid  out  in_valid delayed by DEPTH cycles
// -----------------------------------------------------------------------------
module vl_valid_delay #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in_valid,
  output logic out_valid
);

  generate
    if (DEPTH < 1) begin : g_passthrough
      assign out_valid = in_valid;
    end else begin : g_shift
      logic [DEPTH-1:0] stage_reg;

      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        // Stage 0 samples the input; every later stage samples its predecessor.
        logic stage_in;
        if (gi == 0) begin : g_first
          assign stage_in = in_valid;
        end else begin : g_next
          assign stage_in = stage_reg[gi-1];
        end

        always_ff @(posedge clk or negedge reset_n) begin
          if (!reset_n) begin
            stage_reg[gi] <= 1'b0;
          end else begin
            stage_reg[gi] <= stage_in;
          end
        end
      end

      assign out_valid = stage_reg[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vector_loader.sv
// -----------------------------------------------------------------------------
// vector_loader
// Collects a stream of signed samples into an INPUT_SIZE-wide vector for a
// pipelined adder tree. When the vector is complete it is presented for
// exactly one cycle (vec_valid), then all slots clear and filling restarts.
// sum_valid marks the cycle the downstream tree output belongs to that vector.
//
// Optional feature (macro VECTOR_LOADER_FLUSH_EN): adds a flush input that
// presents a partially filled vector; unfilled slots stay zero.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   in_data    in   WIDTH-bit signed sample
//   in_valid   in   in_data valid this cycle
//   in_ready   out  loader accepts a sample this cycle
//   flush      in   (VECTOR_LOADER_FLUSH_EN only) issue the partial vector
//   vec_data   out  INPUT_SIZE x WIDTH-bit signed vector
//   vec_valid  out  vec_data is a complete, stable vector this cycle
//   sum_valid  out  vec_valid delayed by TREE_LATENCY cycles
// -----------------------------------------------------------------------------
module vector_loader
  import vl_pkg::*;
#(
  parameter int WIDTH        = DEFAULT_WIDTH,
  parameter int INPUT_SIZE   = DEFAULT_INPUT_SIZE,
  parameter int TREE_LATENCY = vl_pkg::tree_latency(INPUT_SIZE)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
`ifdef VECTOR_LOADER_FLUSH_EN
  input  logic                    flush,
`endif
  output logic signed [WIDTH-1:0] vec_data [INPUT_SIZE],
  output logic                    vec_valid,
  output logic                    sum_valid
);

  localparam int IDX_W = $clog2(INPUT_SIZE + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_SIZE - 1);

  vl_state_t        state_reg;
  vl_state_t        state_next;
  logic [IDX_W-1:0] index_reg;

  logic accept;
  logic last_sample;
  logic flush_req;

  // Acceptance is derived straight from the state register (not from in_ready)
  // so the next-state logic below has no combinational feedback through it.
  // While reset_n is low nothing is accepted.
  assign accept      = in_valid && reset_n && (state_reg == FILL);
  assign last_sample = accept && (index_reg == LAST_IDX);

`ifdef VECTOR_LOADER_FLUSH_EN
  // A flush only issues when the vector will hold at least one sample after
  // this edge: either earlier samples exist or one is accepted right now.
  assign flush_req = flush && (state_reg == FILL) && ((index_reg != '0) || accept);
`else
  assign flush_req = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= FILL;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    vec_valid  = 1'b0;
    case (state_reg)
      FILL: begin
        in_ready = reset_n;
        // Final sample and flush in the same cycle still give one ISSUE.
        if (last_sample || flush_req) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        vec_valid  = 1'b1;
        state_next = FILL;
      end
      default: begin
        state_next = FILL;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write index
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index_reg <= '0;
    end else if (state_reg == ISSUE) begin
      index_reg <= '0;
    end else if (accept) begin
      index_reg <= index_reg + IDX_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Vector slots: each slot loads only when the write index points at it, and
  // all of them clear together on the edge that leaves ISSUE.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < INPUT_SIZE; gi++) begin : g_slot
      logic signed [WIDTH-1:0] slot_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          slot_reg <= '0;
        end else if (state_reg == ISSUE) begin
          slot_reg <= '0;
        end else if (accept && (index_reg == IDX_W'(gi))) begin
          slot_reg <= in_data;
        end
      end

      assign vec_data[gi] = slot_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // sum_valid alignment with the adder-tree pipeline
  // ---------------------------------------------------------------------------
  vl_valid_delay #(
    .DEPTH(TREE_LATENCY)
  ) u_valid_delay (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (vec_valid),
    .out_valid(sum_valid)
  );

endmodule

// File: tb/tb_vector_loader.sv
// -----------------------------------------------------------------------------
// tb_vector_loader
// Self-checking bench for vector_loader. A queue-based reference model holds
// the samples of the vector being built and whether the loader is presenting
// a vector; expected sum_valid comes from a TL-deep history queue.
// Flush scenarios are compiled in when VECTOR_LOADER_FLUSH_EN is defined.
// -----------------------------------------------------------------------------
module tb_vector_loader;

  localparam int W  = 17;
  localparam int N  = 32;
  localparam int TL = 4;

  logic                clk      = 1'b0;
  logic                reset_n  = 1'b0;
  logic signed [W-1:0] in_data  = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] vec_data [N];
  logic                vec_valid;
  logic                sum_valid;
`ifdef VECTOR_LOADER_FLUSH_EN
  logic                flush    = 1'b0;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state
  int m_samples[$];
  bit m_issue;
  bit m_hist[$];
  bit exp_sum_valid;
  int vectors_seen;

  always #5 clk = ~clk;

  vector_loader #(
    .WIDTH     (W),
    .INPUT_SIZE(N)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
`ifdef VECTOR_LOADER_FLUSH_EN
    .flush    (flush),
`endif
    .vec_data (vec_data),
    .vec_valid(vec_valid),
    .sum_valid(sum_valid)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Model helpers
  // ---------------------------------------------------------------------------
  function automatic void model_clear();
    m_samples.delete();
    m_issue = 1'b0;
    m_hist.delete();
    for (int i = 0; i < TL; i++) m_hist.push_back(1'b0);
    exp_sum_valid = 1'b0;
  endfunction

  function automatic int exp_slot(input int k);
    return (k < m_samples.size()) ? m_samples[k] : 0;
  endfunction

  function automatic int dut_sum();
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += int'(vec_data[k]);
    return s;
  endfunction

  // One clock: the current inputs are applied at the edge, the model advances,
  // and control returns 1 time unit after the edge.
  task automatic cycle();
    bit acc;
    bit fl;
    int d;
    acc = in_valid && !m_issue;
    d   = int'(in_data);
    fl  = 1'b0;
`ifdef VECTOR_LOADER_FLUSH_EN
    fl  = flush;
`endif
    @(posedge clk);
    #1;
    if (m_issue) begin
      m_samples.delete();
      m_issue = 1'b0;
    end else begin
      if (acc) m_samples.push_back(d);
      if (m_samples.size() == N || (fl && m_samples.size() > 0)) m_issue = 1'b1;
    end
    if (m_issue) vectors_seen++;
    m_hist.push_back(m_issue);
    exp_sum_valid = m_hist.pop_front();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
`ifdef VECTOR_LOADER_FLUSH_EN
    flush = 1'b0;
`endif
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_clear();
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int nz;
    repeat (2) @(posedge clk);
    #1;
    nz = 0;
    for (int k = 0; k < N; k++) if (vec_data[k] !== '0) nz++;
    tests_run++;
    if (nz !== 0) begin tests_failed++; $display("FAIL reset_vec_data: got %0d nonzero slots expected 0", nz); end
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    tests_run++;
    if (vec_valid !== 1'b0 || sum_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset_valids: got vec_valid=%b sum_valid=%b expected 0/0", vec_valid, sum_valid);
    end
    reset_n = 1'b1;
    model_clear();
    #1;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL in_ready_after_reset: got %b expected 1", in_ready); end
    cycle();
    tests_run++;
    if (in_ready !== 1'b1 || vec_valid !== 1'b0) begin
      tests_failed++; $display("FAIL idle_after_reset: got in_ready=%b vec_valid=%b expected 1/0", in_ready, vec_valid);
    end
  endtask

  task automatic test_continuous();
    do_reset();
    for (int i = 1; i <= N; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      cycle();
      if (i < N) begin
        tests_run++;
        if (vec_valid !== 1'b0 || in_ready !== 1'b1) begin
          tests_failed++; $display("FAIL fill_%0d: got vec_valid=%b in_ready=%b expected 0/1", i, vec_valid, in_ready);
        end
      end
    end
    in_valid = 1'b0;
    tests_run++;
    if (vec_valid !== 1'b1 || in_ready !== 1'b0) begin
      tests_failed++; $display("FAIL issue_cycle: got vec_valid=%b in_ready=%b expected 1/0", vec_valid, in_ready);
    end
    tests_run++;
    if (int'(vec_data[0]) !== 1 || int'(vec_data[N-1]) !== 32) begin
      tests_failed++; $display("FAIL cont_ends: got %0d,%0d expected 1,32", int'(vec_data[0]), int'(vec_data[N-1]));
    end
    tests_run++;
    if (dut_sum() !== 528) begin tests_failed++; $display("FAIL cont_sum: got %0d expected 528", dut_sum()); end
    for (int j = 1; j <= TL; j++) begin
      cycle();
      if (j == 1) begin
        tests_run++;
        if (vec_valid !== 1'b0 || vec_data[0] !== '0 || vec_data[N-1] !== '0) begin
          tests_failed++; $display("FAIL issue_exit_clear: got vec_valid=%b d0=%0d d31=%0d expected 0/0/0",
                                   vec_valid, int'(vec_data[0]), int'(vec_data[N-1]));
        end
      end
      tests_run++;
      if (sum_valid !== (j == TL)) begin
        tests_failed++; $display("FAIL sum_valid_delay_%0d: got %b expected %b", j, sum_valid, (j == TL));
      end
    end
  endtask

  task automatic test_pattern();
    int ready_bad;
    do_reset();
    ready_bad = 0;
    in_valid  = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_data = (i == N-1) ? -W'(8) : W'((i % 8) + 1);
      cycle();
      if (i < N-1 && in_ready !== 1'b1) ready_bad++;
    end
    tests_run++;
    if (vec_valid !== 1'b1 || dut_sum() !== 128) begin
      tests_failed++; $display("FAIL pattern_sum: got valid=%b sum=%0d expected 1/128", vec_valid, dut_sum());
    end
    tests_run++;
    if (in_ready !== 1'b0) begin tests_failed++; $display("FAIL pattern_issue_ready: got %b expected 0", in_ready); end
    in_data = W'(1);
    cycle();
    if (in_ready !== 1'b1) ready_bad++;
    cycle();
    if (in_ready !== 1'b1) ready_bad++;
    tests_run++;
    if (ready_bad !== 0) begin tests_failed++; $display("FAIL pattern_ready_fill: got %0d low cycles expected 0", ready_bad); end
    in_valid = 1'b0;
  endtask

  task automatic test_issue_stall();
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_data = W'($urandom_range(0, (1 << W) - 1));
      cycle();
    end
    in_data = W'(77);   // offered during ISSUE and held
    tests_run++;
    if (in_ready !== 1'b0 || vec_valid !== 1'b1) begin
      tests_failed++; $display("FAIL stall_issue: got in_ready=%b vec_valid=%b expected 0/1", in_ready, vec_valid);
    end
    cycle();
    tests_run++;
    if (vec_data[0] !== '0 || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL stall_not_taken: got d0=%0d in_ready=%b expected 0/1", int'(vec_data[0]), in_ready);
    end
    cycle();
    in_valid = 1'b0;
    tests_run++;
    if (int'(vec_data[0]) !== 77 || vec_data[1] !== '0) begin
      tests_failed++; $display("FAIL stall_held_sample: got d0=%0d d1=%0d expected 77/0", int'(vec_data[0]), int'(vec_data[1]));
    end
  endtask

  task automatic test_reset_mid();
    int nz;
    int bad;
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_data = W'(i + 5);
      cycle();
    end
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    nz = 0;
    for (int k = 0; k < N; k++) if (vec_data[k] !== '0) nz++;
    tests_run++;
    if (nz !== 0 || in_ready !== 1'b0 || vec_valid !== 1'b0 || sum_valid !== 1'b0) begin
      tests_failed++; $display("FAIL mid_reset_outputs: got nz=%0d rdy=%b vv=%b sv=%b expected 0/0/0/0",
                               nz, in_ready, vec_valid, sum_valid);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_clear();
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (vec_valid !== 1'b0 || sum_valid !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL mid_reset_quiet: got %0d valid cycles expected 0", bad); end
    // Next 32 samples form a clean vector.
    in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_data = W'(100 + i);
      cycle();
    end
    in_valid = 1'b0;
    tests_run++;
    if (vec_valid !== 1'b1 || int'(vec_data[0]) !== 100 || dut_sum() !== (100 * N + 496)) begin
      tests_failed++; $display("FAIL clean_vector: got vv=%b d0=%0d sum=%0d expected 1/100/%0d",
                               vec_valid, int'(vec_data[0]), dut_sum(), 100 * N + 496);
    end
    // Reset while a sum_valid bit is in flight: it must never appear.
    cycle();
    #2;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_clear();
    bad = 0;
    for (int i = 0; i < TL + 2; i++) begin
      cycle();
      if (sum_valid !== 1'b0) bad++;
    end
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL pending_sum_cleared: got %0d sum_valid cycles expected 0", bad); end
  endtask

`ifdef VECTOR_LOADER_FLUSH_EN
  task automatic test_flush();
    int nz;
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = W'(3);
      cycle();
    end
    in_valid = 1'b0;
    flush    = 1'b1;
    cycle();
    nz = 0;
    for (int k = 5; k < N; k++) if (vec_data[k] !== '0) nz++;
    tests_run++;
    if (vec_valid !== 1'b1 || nz !== 0 || dut_sum() !== 15) begin
      tests_failed++; $display("FAIL flush_partial: got vv=%b nz=%0d sum=%0d expected 1/0/15", vec_valid, nz, dut_sum());
    end
    cycle();   // flush held during ISSUE: ignored
    cycle();   // flush with index 0 and nothing accepted: ignored
    tests_run++;
    if (vec_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_empty: got vv=%b expected 0", vec_valid); end
    // Flush with a non-final accepted sample: stored then issued.
    in_valid = 1'b1;
    in_data  = W'(-9);
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    tests_run++;
    if (vec_valid !== 1'b1 || int'(vec_data[0]) !== -9) begin
      tests_failed++; $display("FAIL flush_with_sample: got vv=%b d0=%0d expected 1/-9", vec_valid, int'(vec_data[0]));
    end
    cycle();
    // Flush together with the final sample: exactly one ISSUE.
    in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      in_data = W'(1);
      flush   = (i == N-1);
      cycle();
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    tests_run++;
    if (vec_valid !== 1'b1 || dut_sum() !== N) begin
      tests_failed++; $display("FAIL flush_final: got vv=%b sum=%0d expected 1/%0d", vec_valid, dut_sum(), N);
    end
    cycle();
    tests_run++;
    if (vec_valid !== 1'b0) begin tests_failed++; $display("FAIL flush_final_single: got vv=%b expected 0", vec_valid); end
  endtask
`endif

  task automatic test_random();
    int bad;
    int first_k;
    do_reset();
    vectors_seen = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = W'($urandom_range(0, (1 << W) - 1));
`ifdef VECTOR_LOADER_FLUSH_EN
      flush    = ($urandom_range(0, 9) == 0);
`endif
      cycle();
      tests_run++;
      if (in_ready !== !m_issue || vec_valid !== m_issue || sum_valid !== exp_sum_valid) begin
        tests_failed++;
        $display("FAIL rand_ctrl_c%0d: got rdy=%b vv=%b sv=%b expected %b/%b/%b",
                 c, in_ready, vec_valid, sum_valid, !m_issue, m_issue, exp_sum_valid);
      end
      bad = 0;
      first_k = 0;
      for (int k = 0; k < N; k++) begin
        if (int'(vec_data[k]) !== exp_slot(k)) begin
          if (bad == 0) first_k = k;
          bad++;
        end
      end
      tests_run++;
      if (bad !== 0) begin
        tests_failed++;
        $display("FAIL rand_vec_c%0d slot%0d: got %0d expected %0d", c, first_k, int'(vec_data[first_k]), exp_slot(first_k));
      end
    end
    in_valid = 1'b0;
`ifdef VECTOR_LOADER_FLUSH_EN
    flush = 1'b0;
`endif
    tests_run++;
    if (vectors_seen < 5) begin
      tests_failed++; $display("FAIL rand_vectors: got %0d issued expected at least 5", vectors_seen);
    end
  endtask

  initial begin
    model_clear();
    vectors_seen = 0;
    test_reset();
    test_continuous();
    test_pattern();
    test_issue_stall();
    test_reset_mid();
`ifdef VECTOR_LOADER_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
